// File: rtl/mac_output_fifo_if.sv
// Sample streams around mac_output_fifo: the MAC-side input (no backpressure)
// and the valid/ready output toward the consumer.
interface mac_output_fifo_if #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 12
);
    logic signed [IN_WIDTH-1:0]  f_in;
    logic                        valid_in;
    logic signed [OUT_WIDTH-1:0] data_out;
    logic                        valid_out;
    logic                        ready_out;

    // master: the environment that feeds MAC results in and drains samples out
    modport master (
        output f_in, valid_in, ready_out,
        input  data_out, valid_out
    );

    modport slave (
        input  f_in, valid_in, ready_out,
        output data_out, valid_out
    );
endinterface

// File: rtl/mac_output_fifo.sv
// Scales and saturates MAC results, buffers them in a first-word-fall-through
// FIFO and drains through valid/ready; sticky overflow/saturation status.
module mac_output_fifo #(
    parameter int IN_WIDTH  = 20,
    parameter int OUT_WIDTH = 12,
    parameter int SHIFT     = 4,
    parameter int DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    mac_output_fifo_if.slave           bus,
    input  logic                       clear_flags,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       sat_flag
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int MAX_I = 2 ** (OUT_WIDTH - 1) - 1;
    localparam int MIN_I = -(2 ** (OUT_WIDTH - 1));
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'(MAX_I);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = IN_WIDTH'(MIN_I);

    logic [OUT_WIDTH-1:0]       mem [DEPTH];
    logic [PW-1:0]              wptr;
    logic [PW-1:0]              rptr;
    logic signed [IN_WIDTH-1:0] shifted;
    logic [OUT_WIDTH-1:0]       scaled;
    logic                       clamp;
    logic                       not_empty;
    logic                       push;
    logic                       pop;
    logic                       drop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Floor-rounding arithmetic shift, then clamp to the signed output range.
    always_comb begin
        shifted = bus.f_in >>> SHIFT;
        clamp   = 1'b0;
        scaled  = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            clamp  = 1'b1;
            scaled = OUT_WIDTH'(MAX_I);
        end else if (shifted < SAT_MIN) begin
            clamp  = 1'b1;
            scaled = OUT_WIDTH'(MIN_I);
        end
    end

    always_comb begin
        not_empty = (count != '0);
        pop       = not_empty && bus.ready_out;
        push      = bus.valid_in && ((count < CW'(DEPTH)) || pop);
        drop      = bus.valid_in && !push;
    end

    assign bus.valid_out = not_empty;
    assign bus.data_out  = not_empty ? mem[rptr] : '0;

    // NOTE: storage has no reset; count gates data_out, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= scaled;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (push) begin
                wptr <= next_ptr(wptr);
            end
            if (pop) begin
                rptr <= next_ptr(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A set event in the same cycle as clear_flags keeps the flag high.
            overflow <= (overflow && !clear_flags) || drop;
            sat_flag <= (sat_flag && !clear_flags) || (push && clamp);
        end
    end
endmodule

// File: tb/tb_mac_output_fifo.sv
// Directed self-checking bench for mac_output_fifo with hand-computed
// expected samples, counts and flags.
module tb_mac_output_fifo;
    localparam int IN_WIDTH  = 20;
    localparam int OUT_WIDTH = 12;
    localparam int DEPTH     = 8;
    localparam int CW        = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          clear_flags;
    logic [CW-1:0] count;
    logic          overflow;
    logic          sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    mac_output_fifo_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

    mac_output_fifo #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .SHIFT    (4),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .clear_flags(clear_flags),
        .count      (count),
        .overflow   (overflow),
        .sat_flag   (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " count"}, int'(count), 0);
        check({tag, " valid_out"}, int'(bus.valid_out), 0);
        check({tag, " data_out"}, int'(bus.data_out), 0);
    endtask

    int mac_exp [4] = '{0, 1, 2, 3};
    int acc;

    initial begin
        reset          = 1'b1;
        clear_flags    = 1'b0;
        bus.f_in       = '0;
        bus.valid_in   = 1'b0;
        bus.ready_out  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset overflow", int'(overflow), 0);
        check("reset sat_flag", int'(sat_flag), 0);
        reset = 1'b0;

        // Pass-through with a ready consumer: occupancy never exceeds one.
        bus.ready_out = 1'b1;
        bus.valid_in  = 1'b1;
        bus.f_in      = 160;
        tick();
        check("pt 160 data", int'(bus.data_out), 10);
        check("pt 160 count", int'(count), 1);
        bus.f_in = -1;
        tick();
        check("pt -1 data", int'(bus.data_out), -1);
        check("pt -1 count", int'(count), 1);
        bus.f_in = 0;
        tick();
        check("pt 0 data", int'(bus.data_out), 0);
        check("pt 0 valid", int'(bus.valid_out), 1);
        check("pt 0 count", int'(count), 1);
        bus.valid_in = 1'b0;
        tick();
        check_idle("pt drained");

        // Saturation and flag clearing.
        bus.valid_in = 1'b1;
        bus.f_in     = 40000;
        tick();
        check("sat max data", int'(bus.data_out), 2047);
        check("sat max flag", int'(sat_flag), 1);
        bus.f_in = -40000;
        tick();
        check("sat min data", int'(bus.data_out), -2048);
        bus.valid_in = 1'b0;
        clear_flags  = 1'b1;
        tick();
        check("sat cleared", int'(sat_flag), 0);
        check("sat drained count", int'(count), 0);
        clear_flags  = 1'b0;
        bus.valid_in = 1'b1;
        bus.f_in     = 32752;
        tick();
        check("exact max data", int'(bus.data_out), 2047);
        check("exact max no sat", int'(sat_flag), 0);
        bus.f_in    = 40000;
        clear_flags = 1'b1;
        tick();
        check("set beats clear", int'(sat_flag), 1);
        bus.valid_in = 1'b0;
        tick();
        check("sat cleared again", int'(sat_flag), 0);
        clear_flags = 1'b0;
        check_idle("sat drained");

        // Backpressure: nine pushes into eight entries, then drain in order.
        bus.ready_out = 1'b0;
        bus.valid_in  = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            bus.f_in = 16 * k;
            tick();
        end
        check("ovf count", int'(count), 8);
        check("ovf flag", int'(overflow), 1);
        check("ovf no sat", int'(sat_flag), 0);
        check("ovf head stable", int'(bus.data_out), 1);
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("ovf drain %0d", k), int'(bus.data_out), k);
            tick();
        end
        check_idle("ovf drained");
        check("ovf sticky", int'(overflow), 1);
        bus.ready_out = 1'b0;
        clear_flags   = 1'b1;
        tick();
        check("ovf cleared", int'(overflow), 0);
        clear_flags = 1'b0;

        // Full with simultaneous push and pop.
        bus.valid_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bus.f_in = 16 * k;
            tick();
        end
        check("full count", int'(count), 8);
        bus.f_in      = 144;
        bus.ready_out = 1'b1;
        tick();
        check("full pp count", int'(count), 8);
        check("full pp head", int'(bus.data_out), 2);
        check("full pp no ovf", int'(overflow), 0);
        bus.valid_in = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            check($sformatf("full drain %0d", k), int'(bus.data_out), k);
            tick();
        end
        check_idle("full drained");

        // Repeated fill/drain so both pointers wrap several times.
        for (int rep = 0; rep < 3; rep++) begin
            bus.ready_out = 1'b0;
            bus.valid_in  = 1'b1;
            for (int k = 0; k < 8; k++) begin
                bus.f_in = 16 * (100 * rep + k);
                tick();
            end
            check($sformatf("wrap %0d count", rep), int'(count), 8);
            bus.valid_in  = 1'b0;
            bus.ready_out = 1'b1;
            for (int k = 0; k < 8; k++) begin
                check($sformatf("wrap %0d data %0d", rep, k), int'(bus.data_out), 100 * rep + k);
                tick();
            end
            check($sformatf("wrap %0d empty", rep), int'(bus.valid_out), 0);
        end

        // Asynchronous reset between edges with data and a flag held.
        bus.ready_out = 1'b0;
        bus.valid_in  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.f_in = (k == 4) ? 40000 : 16 * (k + 1);
            tick();
        end
        bus.valid_in = 1'b0;
        check("pre-rst count", int'(count), 5);
        check("pre-rst sat", int'(sat_flag), 1);
        #2;
        reset = 1'b1;
        #1;
        check_idle("async rst");
        check("async rst overflow", int'(overflow), 0);
        check("async rst sat", int'(sat_flag), 0);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.ready_out = 1'b1;
        bus.valid_in  = 1'b1;
        bus.f_in      = 32;
        tick();
        check("post-rst data", int'(bus.data_out), 2);
        check("post-rst count", int'(count), 1);
        bus.valid_in = 1'b0;
        tick();
        check_idle("post-rst drained");

        // MAC-like stream a=3, b=5: accumulator 15, 30, 45, 60 on back-to-back cycles.
        acc          = 0;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            acc      = acc + 3 * 5;
            bus.f_in = IN_WIDTH'(acc);
            tick();
            check($sformatf("mac data %0d", i), int'(bus.data_out), mac_exp[i]);
            check($sformatf("mac count %0d", i), int'(count), 1);
        end
        bus.valid_in = 1'b0;
        tick();
        check_idle("mac drained");
        check("mac no overflow", int'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_output_fifo.md
Name: mac_output_fifo

Overview:
- Downstream stage of part2_mac. Consumes the MAC's `f`/`valid_out` stream, which has no backpressure.
- Each result is scaled (arithmetic right shift), then saturated to a narrower width.
- Results are buffered in a small first-word-fall-through FIFO and drained through a valid/ready handshake.
- Sticky overflow and saturation flags, plus an occupancy count, are exported for status.

Parameters:
IN_WIDTH, 20, width of signed MAC result `f_in`
OUT_WIDTH, 12, width of signed stored/output sample
SHIFT, 4, arithmetic right-shift amount applied before saturation (0..IN_WIDTH-1)
DEPTH, 8, FIFO entries (>=2, need not be a power of 2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
f_in  in  IN_WIDTH  signed MAC result (connects to MAC `f`)
valid_in  in  1  f_in valid this cycle (connects to MAC `valid_out`)
clear_flags  in  1  synchronous clear of overflow and sat_flag
data_out  out  OUT_WIDTH  signed head-of-FIFO sample
valid_out  out  1  FIFO non-empty
ready_out  in  1  consumer accepts data_out this cycle
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: a valid_in sample was dropped
sat_flag  out  1  sticky: an accepted sample was clamped

Behaviour:
- Reset (async assert, any time, including mid-operation): while reset is high, all of the following hold without waiting for a clock edge:
  - count=0, read/write pointers=0
  - valid_out=0, data_out=0
  - overflow=0, sat_flag=0
  - FIFO contents are don't-care.
- Scaling:
  - s = f_in >>> SHIFT, sign-preserving, floor rounding (so -1 >>> 4 = -1).
  - If s > 2^(OUT_WIDTH-1)-1, store max; if s < -2^(OUT_WIDTH-1), store min; otherwise store s truncated to OUT_WIDTH.
  - Scaling is combinational on the write side; no extra pipeline stage.
- push = valid_in && (count<DEPTH || pop).
- pop = valid_out && ready_out.
- Write: on push, mem[wptr] <= scaled value; wptr advances, wrapping DEPTH-1 -> 0.
- Read: data_out = mem[rptr] combinationally when count>0, else 0. On pop, rptr advances, wrapping DEPTH-1 -> 0.
- count:
  - +1 on push only; -1 on pop only.
  - Unchanged on push and pop together, including when full and when count==1.
- Latency: a sample pushed at edge N is visible on data_out/valid_out after edge N. There is no empty-bypass (same-cycle input-to-output).
- Full, valid_in=1, no pop: the sample is dropped, overflow<=1, FIFO unchanged.
- Empty, ready_out=1: no pop, nothing changes.
- sat_flag <= 1 when a pushed sample was clamped. Dropped samples never set sat_flag.
- clear_flags=1 clears both flags at the edge. A set event in the same cycle wins (the flag stays 1).
- valid_out = (count!=0), registered-state derived.
- data_out is stable while valid_out=1 and ready_out=0.
- Order is strictly FIFO; no reordering or duplication.

Test Plan:
- Basic pass-through: reset, ready_out=1, inputs f_in=160, then -1, then 0, each with valid_in=1 -> data_out 10, -1, 0 each 1 cycle after input; count never exceeds 1.
- Saturation: f_in=40000 then -40000 (valid_in=1) -> stored 2047 and -2048; sat_flag=1. Then clear_flags=1 with no new clamp -> sat_flag=0 next cycle. Also f_in=32752 -> 2047 with sat_flag unchanged.
- Overflow/backpressure: ready_out=0, push f_in=16*k for k=1..9 -> after 9th push count=8, overflow=1. Then ready_out=1 -> drain 1..8 in order, count falls to 0, valid_out=0; overflow stays 1.
- Full simultaneous push/pop: fill with 1..8, then valid_in=1 (f_in=144) and ready_out=1 on the same cycle -> pops 1, count stays 8, later drains 2..9. Wrap-around exercised over 3 full fill/drain cycles.
- Reset mid-operation: count=5, assert reset between clock edges -> count=0, valid_out=0, data_out=0, flags 0 before the next edge. After deassert, a push of f_in=32 yields 2.
- MAC hookup: drive part2_mac with a=3, b=5 over 4 valid cycles; feed its f/valid_out into this block with ready_out=1 -> outputs are floor(f/16) of each MAC output, in order, with none dropped.
